// File: rtl/core_types_pkg.sv
// Shared widths and record types for the BTB update path (upper-PC table + BTB write).
package core_types_pkg;
    localparam int UPPER_PC_WIDTH   = 20;
    localparam int LOG_UPCT_ENTRIES = 4;
    localparam int LOWER_PC_WIDTH   = 32 - UPPER_PC_WIDTH;
    localparam int BTB_INFO_WIDTH   = 8;

    typedef struct packed {
        logic [31:0]               start_PC;
        logic [31:0]               target_PC;
        logic [BTB_INFO_WIDTH-1:0] info;
    } btb_update_t;

    typedef struct packed {
        logic [31:0]                 start_PC;
        logic [LOWER_PC_WIDTH-1:0]   lower_target;
        logic [LOG_UPCT_ENTRIES-1:0] upct_index;
        logic [BTB_INFO_WIDTH-1:0]   info;
    } btb_wr_t;
endpackage

// File: rtl/btb_update_buffer_if.sv
// Bus bundle between branch unit, upct update port, BTB write port and the update buffer.
interface btb_update_buffer_if;
    import core_types_pkg::*;

    logic                        enq_valid;
    logic                        enq_ready;
    logic [31:0]                 enq_start_PC;
    logic [31:0]                 enq_target_PC;
    logic [BTB_INFO_WIDTH-1:0]   enq_info;
    logic                        upct_update0_valid;
    logic [31:0]                 upct_update0_full_PC;
    logic [LOG_UPCT_ENTRIES-1:0] upct_update1_index;
    logic                        btb_wr_valid;
    logic                        btb_wr_ready;
    logic [31:0]                 btb_wr_start_PC;
    logic [LOWER_PC_WIDTH-1:0]   btb_wr_lower_target;
    logic [LOG_UPCT_ENTRIES-1:0] btb_wr_upct_index;
    logic [BTB_INFO_WIDTH-1:0]   btb_wr_info;

    modport master (
        output enq_valid, enq_start_PC, enq_target_PC, enq_info,
        output upct_update1_index, btb_wr_ready,
        input  enq_ready, upct_update0_valid, upct_update0_full_PC,
        input  btb_wr_valid, btb_wr_start_PC, btb_wr_lower_target, btb_wr_upct_index, btb_wr_info
    );

    modport slave (
        input  enq_valid, enq_start_PC, enq_target_PC, enq_info,
        input  upct_update1_index, btb_wr_ready,
        output enq_ready, upct_update0_valid, upct_update0_full_PC,
        output btb_wr_valid, btb_wr_start_PC, btb_wr_lower_target, btb_wr_upct_index, btb_wr_info
    );
endinterface

// File: rtl/btb_update_out_q.sv
// Two-entry queue of compressed BTB writes; overflow is prevented upstream by the credit check.
module btb_update_out_q
    import core_types_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  logic    enq,
    input  btb_wr_t enq_data,
    input  logic    deq,
    output logic [1:0] count,
    output btb_wr_t head
);
    btb_wr_t    entries_q [2];
    btb_wr_t    entries_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (enq) begin
            entries_d[wr_ptr_q] = enq_data;
            wr_ptr_d            = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            entries_q <= '{default: '0};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign count = count_q;
    assign head  = entries_q[rd_ptr_q];
endmodule

// File: rtl/btb_update_buffer.sv
// Buffers resolved-branch BTB updates, runs each through upct (update0 -> index on update1)
// and emits compressed BTB writes in strict arrival order.
module btb_update_buffer
    import core_types_pkg::*;
#(
    parameter int BUF_ENTRIES     = 4,
    parameter int LOG_BUF_ENTRIES = $clog2(BUF_ENTRIES)
) (
    input logic                CLK,
    input logic                RST,
    btb_update_buffer_if.slave b
);
    btb_update_t                fifo_q [BUF_ENTRIES];
    btb_update_t                fifo_d [BUF_ENTRIES];
    logic [LOG_BUF_ENTRIES:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG_BUF_ENTRIES:0]   rd_ptr_q, rd_ptr_d;
    logic                       s1_valid_q, s1_valid_d;
    logic [31:0]                s1_start_PC_q, s1_start_PC_d;
    logic [LOWER_PC_WIDTH-1:0]  s1_lower_target_q, s1_lower_target_d;
    logic [BTB_INFO_WIDTH-1:0]  s1_info_q, s1_info_d;

    logic        fifo_empty, fifo_full, enq_fire, pop, credit_ok, btb_fire;
    logic [1:0]  out_count;
    logic [2:0]  credit_sum;
    btb_update_t head;
    btb_wr_t     out_enq_data, out_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[LOG_BUF_ENTRIES] != rd_ptr_q[LOG_BUF_ENTRIES]) &&
                        (wr_ptr_q[LOG_BUF_ENTRIES-1:0] == rd_ptr_q[LOG_BUF_ENTRIES-1:0]);
    assign head       = fifo_q[rd_ptr_q[LOG_BUF_ENTRIES-1:0]];

    assign b.enq_ready = ~RST & ~fifo_full;
    assign enq_fire    = b.enq_valid & b.enq_ready;

    // Count what the output queue will hold after this edge if one more entry enters S1;
    // S1 cannot stall, so pop only when that slot is already guaranteed.
    assign btb_fire   = b.btb_wr_valid & b.btb_wr_ready;
    assign credit_sum = {1'b0, out_count} + {2'b00, s1_valid_q} - {2'b00, btb_fire};
    assign credit_ok  = (credit_sum < 3'd2);
    assign pop        = ~fifo_empty & credit_ok & ~RST;

    assign b.upct_update0_valid   = pop;
    assign b.upct_update0_full_PC = head.target_PC;

    always_comb begin
        fifo_d            = fifo_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        s1_valid_d        = pop;
        s1_start_PC_d     = s1_start_PC_q;
        s1_lower_target_d = s1_lower_target_q;
        s1_info_d         = s1_info_q;
        if (enq_fire) begin
            fifo_d[wr_ptr_q[LOG_BUF_ENTRIES-1:0]] = '{start_PC:  b.enq_start_PC,
                                                      target_PC: b.enq_target_PC,
                                                      info:      b.enq_info};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + 1'b1;
            s1_start_PC_d     = head.start_PC;
            s1_lower_target_d = head.target_PC[LOWER_PC_WIDTH-1:0];
            s1_info_d         = head.info;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_q            <= '{default: '0};
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            s1_valid_q        <= 1'b0;
            s1_start_PC_q     <= '0;
            s1_lower_target_q <= '0;
            s1_info_q         <= '0;
        end else begin
            fifo_q            <= fifo_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            s1_valid_q        <= s1_valid_d;
            s1_start_PC_q     <= s1_start_PC_d;
            s1_lower_target_q <= s1_lower_target_d;
            s1_info_q         <= s1_info_d;
        end
    end

    assign out_enq_data = '{start_PC:     s1_start_PC_q,
                            lower_target: s1_lower_target_q,
                            upct_index:   b.upct_update1_index,
                            info:         s1_info_q};

    btb_update_out_q u_out_q (
        .CLK      (CLK),
        .RST      (RST),
        .enq      (s1_valid_q),
        .enq_data (out_enq_data),
        .deq      (btb_fire),
        .count    (out_count),
        .head     (out_head)
    );

    assign b.btb_wr_valid        = (out_count != 2'd0);
    assign b.btb_wr_start_PC     = out_head.start_PC;
    assign b.btb_wr_lower_target = out_head.lower_target;
    assign b.btb_wr_upct_index   = out_head.upct_index;
    assign b.btb_wr_info         = out_head.info;
endmodule

// File: tb/tb_btb_update_buffer.sv
// Directed bench for btb_update_buffer with a queue-level reference model checked every cycle.
module tb_btb_update_buffer;
    import core_types_pkg::*;

    localparam int BUF = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    btb_update_buffer_if u();

    btb_update_buffer #(.BUF_ENTRIES(BUF)) dut (
        .CLK (CLK),
        .RST (RST),
        .b   (u.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- upct stub: index = stub_base + n-th update0 since reset
    logic [3:0] stub_base = 4'd0;
    int         stub_n    = 0;
    logic       u0_seen   = 1'b0;
    always @(negedge CLK) u0_seen = u.upct_update0_valid;
    always @(posedge CLK) begin
        cyc++;
        if (RST) stub_n = 0;
        #2;
        if (u0_seen) begin
            u.upct_update1_index = stub_base + 4'(stub_n);
            stub_n++;
        end else begin
            u.upct_update1_index = 4'hF;
        end
    end

    // ---------------- reference model: three queues and the credit rule
    btb_update_t m_fifo[$];
    btb_wr_t     m_out[$];
    btb_update_t m_s1;
    logic        m_s1v  = 1'b0;
    logic        chk_en = 1'b0;

    always @(posedge CLK) begin : model_step
        logic r, f, p;
        btb_wr_t w;
        r = !RST && (m_fifo.size() < BUF);
        f = (m_out.size() != 0) && u.btb_wr_ready;
        p = !RST && (m_fifo.size() != 0) && ((m_out.size() + int'(m_s1v) - int'(f)) < 2);
        if (RST) begin
            m_fifo.delete();
            m_out.delete();
            m_s1v  = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (f) void'(m_out.pop_front());
            if (m_s1v) begin
                w.start_PC     = m_s1.start_PC;
                w.lower_target = m_s1.target_PC[LOWER_PC_WIDTH-1:0];
                w.upct_index   = u.upct_update1_index;
                w.info         = m_s1.info;
                m_out.push_back(w);
            end
            if (p) m_s1 = m_fifo.pop_front();
            m_s1v = p;
            if (u.enq_valid && r)
                m_fifo.push_back('{start_PC: u.enq_start_PC, target_PC: u.enq_target_PC, info: u.enq_info});
        end
    end

    always @(negedge CLK) begin : compare
        logic r, f, p;
        if (chk_en) begin
            r = !RST && (m_fifo.size() < BUF);
            f = (m_out.size() != 0) && u.btb_wr_ready;
            p = !RST && (m_fifo.size() != 0) && ((m_out.size() + int'(m_s1v) - int'(f)) < 2);
            check("enq_ready", 32'(u.enq_ready), 32'(r));
            check("update0_valid", 32'(u.upct_update0_valid), 32'(p));
            if (p) check("update0_full_PC", u.upct_update0_full_PC, m_fifo[0].target_PC);
            check("btb_wr_valid", 32'(u.btb_wr_valid), 32'(m_out.size() != 0));
            if (m_out.size() != 0) begin
                check("btb_wr_start_PC", u.btb_wr_start_PC, m_out[0].start_PC);
                check("btb_wr_lower_target", 32'(u.btb_wr_lower_target), 32'(m_out[0].lower_target));
                check("btb_wr_upct_index", 32'(u.btb_wr_upct_index), 32'(m_out[0].upct_index));
                check("btb_wr_info", 32'(u.btb_wr_info), 32'(m_out[0].info));
            end
        end
    end

    // ---------------- handshake logs
    logic [31:0] acc_log[$];
    logic [31:0] wr_start[$];
    logic [3:0]  wr_idx[$];
    int          wr_cyc[$];
    always @(negedge CLK) begin
        if (u.enq_valid && u.enq_ready) acc_log.push_back(u.enq_start_PC);
        if (u.btb_wr_valid && u.btb_wr_ready) begin
            wr_start.push_back(u.btb_wr_start_PC);
            wr_idx.push_back(u.btb_wr_upct_index);
            wr_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers
    logic [31:0] seq = 32'd0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic drive_seq();
        u.enq_valid     = 1'b1;
        u.enq_start_PC  = 32'h4000_0000 + (seq << 2);
        u.enq_target_PC = 32'hC000_0000 + seq * 32'h0000_0111;
        u.enq_info      = seq[7:0] ^ 8'hA5;
    endtask

    // Offer fresh entries, advancing only when one is accepted.
    task automatic offer_until(input int n, input int bound, input string name);
        int got = 0;
        int c   = 0;
        while (got < n && c < bound) begin
            drive_seq();
            #3;
            if (u.enq_ready) begin
                seq = seq + 1;
                got++;
            end
            tick();
            c++;
        end
        u.enq_valid = 1'b0;
        check(name, 32'(got), 32'(n));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : stim
        int bw, ba, n;
        u.enq_valid     = 1'b0;
        u.enq_start_PC  = '0;
        u.enq_target_PC = '0;
        u.enq_info      = '0;
        u.btb_wr_ready  = 1'b1;

        // 1: reset state and single update latency
        stub_base = 4'd3;
        do_reset();
        #1;
        check("rst_enq_ready", 32'(u.enq_ready), 32'd1);
        check("rst_update0_valid", 32'(u.upct_update0_valid), 32'd0);
        check("rst_update0_full_PC", u.upct_update0_full_PC, 32'd0);
        check("rst_btb_wr_valid", 32'(u.btb_wr_valid), 32'd0);
        check("rst_btb_wr_data", u.btb_wr_start_PC | 32'(u.btb_wr_lower_target) |
              32'(u.btb_wr_upct_index) | 32'(u.btb_wr_info), 32'd0);
        u.enq_valid     = 1'b1;
        u.enq_start_PC  = 32'h0000_1000;
        u.enq_target_PC = 32'h8000_1234;
        u.enq_info      = 8'h5A;
        tick();
        u.enq_valid = 1'b0;
        check("t1_update0_valid", 32'(u.upct_update0_valid), 32'd1);
        check("t1_update0_PC", u.upct_update0_full_PC, 32'h8000_1234);
        tick();
        check("t2_btb_wr_valid", 32'(u.btb_wr_valid), 32'd0);
        tick();
        check("t3_btb_wr_valid", 32'(u.btb_wr_valid), 32'd1);
        check("t3_start_PC", u.btb_wr_start_PC, 32'h0000_1000);
        check("t3_lower_target", 32'(u.btb_wr_lower_target), 32'h234);
        check("t3_upct_index", 32'(u.btb_wr_upct_index), 32'd3);
        check("t3_info", 32'(u.btb_wr_info), 32'h5A);
        tick();

        // 2: streaming, 8 back-to-back
        stub_base = 4'd0;
        do_reset();
        bw = wr_start.size();
        for (int i = 0; i < 8; i++) begin
            u.enq_valid     = 1'b1;
            u.enq_start_PC  = 32'h0000_2000 + 32'(i * 4);
            u.enq_target_PC = 32'h9000_0000 + 32'(i * 32'h111);
            u.enq_info      = 8'(i);
            tick();
        end
        u.enq_valid = 1'b0;
        repeat (8) tick();
        check("stream_count", 32'(wr_start.size() - bw), 32'd8);
        if (wr_start.size() - bw == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("stream_index", 32'(wr_idx[bw + i]), 32'(i));
                check("stream_start", wr_start[bw + i], 32'h0000_2000 + 32'(i * 4));
            end
            check("stream_back_to_back", 32'(wr_cyc[bw + 7] - wr_cyc[bw]), 32'd7);
        end

        // 3: backpressure, 10 offered, 6 accepted
        do_reset();
        u.btb_wr_ready = 1'b0;
        ba = acc_log.size();
        bw = wr_start.size();
        for (int i = 0; i < 10; i++) begin
            drive_seq();
            seq = seq + 1;
            tick();
        end
        u.enq_valid = 1'b0;
        check("bp_accepted", 32'(acc_log.size() - ba), 32'd6);
        check("bp_enq_ready", 32'(u.enq_ready), 32'd0);
        check("bp_no_write", 32'(wr_start.size() - bw), 32'd0);
        u.btb_wr_ready = 1'b1;
        repeat (10) tick();
        n = wr_start.size() - bw;
        check("bp_drained", 32'(n), 32'd6);
        if (n == 6 && acc_log.size() - ba == 6) begin
            for (int i = 0; i < 6; i++) check("bp_order", wr_start[bw + i], acc_log[ba + i]);
            check("bp_one_per_cycle", 32'(wr_cyc[bw + 5] - wr_cyc[bw]), 32'd5);
        end

        // 4: full FIFO, then release with enqueue held; wrap over 20 more updates
        do_reset();
        u.btb_wr_ready = 1'b0;
        ba = acc_log.size();
        bw = wr_start.size();
        offer_until(6, 20, "sim_fill");
        u.btb_wr_ready = 1'b1;
        offer_until(20, 80, "sim_stream");
        repeat (12) tick();
        n = wr_start.size() - bw;
        check("sim_total", 32'(n), 32'd26);
        if (n == acc_log.size() - ba)
            for (int i = 0; i < n; i++) check("sim_order", wr_start[bw + i], acc_log[ba + i]);

        // 5: reset with FIFO, S1 and output queue all occupied
        do_reset();
        u.btb_wr_ready = 1'b0;
        repeat (3) begin
            drive_seq();
            seq = seq + 1;
            tick();
        end
        u.enq_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("rm_btb_wr_valid", 32'(u.btb_wr_valid), 32'd0);
        check("rm_update0_valid", 32'(u.upct_update0_valid), 32'd0);
        u.btb_wr_ready = 1'b1;
        bw = wr_start.size();
        repeat (4) tick();
        check("rm_no_write", 32'(wr_start.size() - bw), 32'd0);
        u.enq_valid     = 1'b1;
        u.enq_start_PC  = 32'h0000_7770;
        u.enq_target_PC = 32'h1234_5ABC;
        u.enq_info      = 8'h3C;
        tick();
        u.enq_valid = 1'b0;
        check("rm_update0_valid_t1", 32'(u.upct_update0_valid), 32'd1);
        tick();
        check("rm_btb_wr_valid_t2", 32'(u.btb_wr_valid), 32'd0);
        tick();
        check("rm_btb_wr_valid_t3", 32'(u.btb_wr_valid), 32'd1);
        check("rm_start_t3", u.btb_wr_start_PC, 32'h0000_7770);
        check("rm_lower_t3", 32'(u.btb_wr_lower_target), 32'hABC);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
